trace_frame_rx: RTL and testbench

Receives one complete side-channel trace frame byte-by-byte from a `uart_rx` instance and reassembles it: 16 plaintext bytes, 16 key bytes, 16 ciphertext bytes, then `SAMPLES` on-chip sensor bytes. It sits behind `uart_rx` on a collector FPGA or in a loopback bench, acting as the far end of the trace transmit sequence. The block presents the reassembled PT/KEY/CT words and a readable sample buffer to downstream logic, with a completion pulse and an inter-byte timeout.

---
 rtl/trace_pkg.sv | 35 +++
 rtl/trace_sample_ram.sv | 43 ++++
 rtl/trace_frame_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_trace_frame_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants and state encoding for the trace frame receiver
package trace_pkg;

   // Number of bytes in each of the PT, KEY and CT header fields
   localparam int HDR_LEN = 16;

   // Sample value that flags ciphertext-valid inside the trace
   localparam logic [7:0] MARKER_VAL_DEFAULT = 8'hFF;

   // Order in which frame fields arrive on the wire
   typedef enum logic [1:0] {
      FLD_PT   = 2'd0,
      FLD_KEY  = 2'd1,
      FLD_CT   = 2'd2,
      FLD_SAMP = 2'd3
   } trace_field_e;

   // Receiver states follow the field order one-to-one
   localparam logic [1:0] S_PT   = FLD_PT;
   localparam logic [1:0] S_KEY  = FLD_KEY;
   localparam logic [1:0] S_CT   = FLD_CT;
   localparam logic [1:0] S_SAMP = FLD_SAMP;

   // State that follows a completed header field
   function automatic logic [1:0] next_field(input logic [1:0] s);
      logic [1:0] n;
      case (s)
         S_PT:    n = S_KEY;
         S_KEY:   n = S_CT;
         default: n = S_SAMP;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/trace_sample_ram.sv
// rtl/trace_sample_ram.sv - sample buffer, single write port, registered read port
module trace_sample_ram
   import trace_pkg::*;
#(
   parameter int SAMPLES = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [$clog2(SAMPLES)-1:0] waddr,
   input  logic [7:0]                 wdata,
   input  logic [$clog2(SAMPLES)-1:0] raddr,
   output logic [7:0]                 rdata
);

   logic [7:0] mem [SAMPLES];
   logic [7:0] rdata_d;
   logic [7:0] rdata_q;

   // Write port; contents are deliberately left unreset so the array maps to block RAM
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read address lookup feeding the output register
   always_comb begin
      rdata_d = mem[raddr];
   end

   // Output register; only this register is cleared so outputs read 0 after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/trace_frame_rx.sv
// rtl/trace_frame_rx.sv - trace frame reassembler (optional marker scan: TRACE_MARKER_EN)
module trace_frame_rx
   import trace_pkg::*;
#(
   parameter int SAMPLES        = 1024,
   parameter int TIMEOUT_CYCLES = 100000
`ifdef TRACE_MARKER_EN
   ,
   parameter logic [7:0] MARKER_VAL = MARKER_VAL_DEFAULT
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rx_dv,
   input  logic [7:0]                 rx_byte,
   input  logic [$clog2(SAMPLES)-1:0] rd_addr,
   output logic [7:0]                 rd_data,
   output logic [127:0]               pt,
   output logic [127:0]               key,
   output logic [127:0]               ct,
   output logic                       frame_valid,
   output logic                       frame_err,
   output logic                       busy,
   output logic [15:0]                frame_cnt,
   output logic                       marker_seen,
   output logic [$clog2(SAMPLES)-1:0] marker_idx
);

   localparam int AW = $clog2(SAMPLES);
   // Counter must hold both the header index (0..15) and the sample index
   localparam int CW = (AW > 4) ? AW : 4;
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_LEN - 1);
   localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [127:0]  w_pt_q, w_pt_d;
   logic [127:0]  w_key_q, w_key_d;
   logic [127:0]  w_ct_q, w_ct_d;
   logic [127:0]  pt_q, pt_d;
   logic [127:0]  key_q, key_d;
   logic [127:0]  ct_q, ct_d;
   logic          frame_valid_q, frame_valid_d;
   logic          frame_err_q, frame_err_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;

   logic idle;
   logic ram_we;

   assign idle   = (state_q == S_PT) && (cnt_q == '0);
   assign ram_we = rx_dv && (state_q == S_SAMP);

   // Frame sequencing: header shifting, sample counting, completion and inter-byte timeout
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      gap_d         = gap_q;
      w_pt_d        = w_pt_q;
      w_key_d       = w_key_q;
      w_ct_d        = w_ct_q;
      pt_d          = pt_q;
      key_d         = key_q;
      ct_d          = ct_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      frame_cnt_d   = frame_cnt_q;

      if (rx_dv) begin
         // A byte always wins over a timeout expiring in the same cycle
         gap_d = '0;
         case (state_q)
            S_PT:    w_pt_d  = {w_pt_q[119:0], rx_byte};
            S_KEY:   w_key_d = {w_key_q[119:0], rx_byte};
            S_CT:    w_ct_d  = {w_ct_q[119:0], rx_byte};
            default: ;
         endcase

         if (state_q != S_SAMP) begin
            if (cnt_q == HDR_LAST) begin
               state_d = next_field(state_q);
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (cnt_q == SAMP_LAST) begin
               pt_d          = w_pt_q;
               key_d         = w_key_q;
               ct_d          = w_ct_q;
               frame_cnt_d   = frame_cnt_q + 16'd1;
               frame_valid_d = 1'b1;
               state_d       = S_PT;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end else if (!idle) begin
         // The TIMEOUT_CYCLES-th consecutive idle cycle of a frame aborts it
         if (gap_q == GAP_LAST) begin
            frame_err_d = 1'b1;
            state_d     = S_PT;
            cnt_d       = '0;
            gap_d       = '0;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end
   end

   // Frame state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_PT;
         cnt_q         <= '0;
         gap_q         <= '0;
         w_pt_q        <= '0;
         w_key_q       <= '0;
         w_ct_q        <= '0;
         pt_q          <= '0;
         key_q         <= '0;
         ct_q          <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         gap_q         <= gap_d;
         w_pt_q        <= w_pt_d;
         w_key_q       <= w_key_d;
         w_ct_q        <= w_ct_d;
         pt_q          <= pt_d;
         key_q         <= key_d;
         ct_q          <= ct_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   trace_sample_ram #(
      .SAMPLES(SAMPLES)
   ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (ram_we),
      .waddr(cnt_q[AW-1:0]),
      .wdata(rx_byte),
      .raddr(rd_addr),
      .rdata(rd_data)
   );

`ifdef TRACE_MARKER_EN
   logic          frame_start;
   logic          frame_done;
   logic          hit;
   logic          mk_w_q, mk_w_d;
   logic [AW-1:0] mk_wi_q, mk_wi_d;
   logic          marker_seen_q, marker_seen_d;
   logic [AW-1:0] marker_idx_q, marker_idx_d;

   assign frame_start = rx_dv && idle;
   assign frame_done  = ram_we && (cnt_q == SAMP_LAST);
   assign hit         = ram_we && (rx_byte == MARKER_VAL);

   // First-match marker scan; the last sample itself may be the first match
   always_comb begin
      mk_w_d        = mk_w_q;
      mk_wi_d       = mk_wi_q;
      marker_seen_d = marker_seen_q;
      marker_idx_d  = marker_idx_q;
      if (frame_start) begin
         mk_w_d = 1'b0;
      end
      if (hit && !mk_w_q) begin
         mk_w_d  = 1'b1;
         mk_wi_d = cnt_q[AW-1:0];
      end
      if (frame_done) begin
         marker_seen_d = mk_w_q || hit;
         marker_idx_d  = mk_w_q ? mk_wi_q : (hit ? cnt_q[AW-1:0] : '0);
      end
   end

   // Marker registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mk_w_q        <= 1'b0;
         mk_wi_q       <= '0;
         marker_seen_q <= 1'b0;
         marker_idx_q  <= '0;
      end else begin
         mk_w_q        <= mk_w_d;
         mk_wi_q       <= mk_wi_d;
         marker_seen_q <= marker_seen_d;
         marker_idx_q  <= marker_idx_d;
      end
   end

   assign marker_seen = marker_seen_q;
   assign marker_idx  = marker_idx_q;
`else
   assign marker_seen = 1'b0;
   assign marker_idx  = '0;
`endif

   assign pt          = pt_q;
   assign key         = key_q;
   assign ct          = ct_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign busy        = !idle;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_trace_frame_rx.sv
// tb/tb_trace_frame_rx.sv - directed self-checking bench for trace_frame_rx
module tb_trace_frame_rx;

   localparam int SAMPLES = 1024;
   localparam int TMO     = 64;
   localparam int AW      = 10;

   localparam logic [127:0] P0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0ef0;
   localparam logic [127:0] C0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] P1 = {128{1'b1}};
   localparam logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;

   logic          clk;
   logic          rst;
   logic          rx_dv;
   logic [7:0]    rx_byte;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [127:0]  pt, key, ct;
   logic          frame_valid, frame_err, busy;
   logic [15:0]   frame_cnt;
   logic          marker_seen;
   logic [AW-1:0] marker_idx;

   int n_tests = 0;
   int n_fail  = 0;
   int fv_count = 0;
   int fe_count = 0;

   trace_frame_rx #(
      .SAMPLES(SAMPLES),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .pt(pt), .key(key), .ct(ct),
      .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy),
      .frame_cnt(frame_cnt), .marker_seen(marker_seen), .marker_idx(marker_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid) fv_count++;
      if (frame_err) fe_count++;
   end

   function automatic logic [7:0] samp(input int mode, input int i);
      if (mode == 0) return (i == 0) ? 8'd250 : (i == 700) ? 8'd255 : 8'd100;
      return 8'(i % 200);
   endfunction

   task automatic send_byte(input logic [7:0] b);
      rx_dv = 1'b1;
      rx_byte = b;
      @(posedge clk);
      #1;
      rx_dv = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c,
                             input int mode, input int gap_at, input int gap_len);
      for (int i = 0; i < 48 + SAMPLES; i++) begin
         logic [7:0] b;
         if (i < 16) b = p[127 - 8*i -: 8];
         else if (i < 32) b = k[127 - 8*(i-16) -: 8];
         else if (i < 48) b = c[127 - 8*(i-32) -: 8];
         else b = samp(mode, i - 48);
         send_byte(b);
         if (i == gap_at) idle_cycles(gap_len);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; rd_addr = '0;
      idle_cycles(3);
      n_tests++; if (pt !== 128'h0 || key !== 128'h0 || ct !== 128'h0) begin n_fail++; $display("FAIL reset_words got pt=%h key=%h ct=%h want 0", pt, key, ct); end
      n_tests++; if ({frame_valid, frame_err, busy, marker_seen} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {frame_valid, frame_err, busy, marker_seen}); end
      n_tests++; if (frame_cnt !== 16'd0 || marker_idx !== '0 || rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got cnt=%0d idx=%0d rd=%0d want 0", frame_cnt, marker_idx, rd_data); end
      rst = 1'b0;
      idle_cycles(1);
   endtask

   task automatic test_full_frame();
      int fv0;
      logic       exp_seen;
      logic [AW-1:0] exp_idx;
      int addrs [4];
`ifdef TRACE_MARKER_EN
      exp_seen = 1'b1; exp_idx = 10'd700;
`else
      exp_seen = 1'b0; exp_idx = 10'd0;
`endif
      fv0 = fv_count;
      send_frame(P0, K0, C0, 0, -1, 0);
      n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL full_fv_timing got %b want 1", frame_valid); end
      n_tests++; if (pt !== P0) begin n_fail++; $display("FAIL full_pt got %h want %h", pt, P0); end
      n_tests++; if (key !== K0) begin n_fail++; $display("FAIL full_key got %h want %h", key, K0); end
      n_tests++; if (ct !== C0) begin n_fail++; $display("FAIL full_ct got %h want %h", ct, C0); end
      n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL full_cnt got %0d want 1", frame_cnt); end
      n_tests++; if (marker_seen !== exp_seen || marker_idx !== exp_idx) begin n_fail++; $display("FAIL full_marker got %b/%0d want %b/%0d", marker_seen, marker_idx, exp_seen, exp_idx); end
      idle_cycles(3);
      n_tests++; if (fv_count - fv0 !== 1) begin n_fail++; $display("FAIL full_fv_pulses got %0d want 1", fv_count - fv0); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy got %b want 0", busy); end
      addrs = '{0, 700, 1, 1023};
      foreach (addrs[j]) begin
         rd_addr = 10'(addrs[j]);
         idle_cycles(1);
         n_tests++; if (rd_data !== samp(0, addrs[j])) begin n_fail++; $display("FAIL full_rd[%0d] got %0d want %0d", addrs[j], rd_data, samp(0, addrs[j])); end
      end
   endtask

   task automatic test_back_to_back();
      int fv0;
      rst = 1'b1;
      idle_cycles(1);
      rst = 1'b0;
      fv0 = fv_count;
      send_frame(P0, K0, C0, 0, -1, 0);
      send_frame(P1, K0, C0, 0, -1, 0);
      idle_cycles(2);
      n_tests++; if (fv_count - fv0 !== 2) begin n_fail++; $display("FAIL b2b_fv_pulses got %0d want 2", fv_count - fv0); end
      n_tests++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_cnt got %0d want 2", frame_cnt); end
      n_tests++; if (pt !== P1 || key !== K0 || ct !== C0) begin n_fail++; $display("FAIL b2b_words got pt=%h key=%h ct=%h", pt, key, ct); end
   endtask

   task automatic test_timeout();
      int fe0, fv0;
      fe0 = fe_count;
      for (int i = 0; i < 20; i++) send_byte(8'hA0 + 8'(i));
      idle_cycles(TMO - 1);
      n_tests++; if (busy !== 1'b1 || frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early got busy=%b err=%b want 1/0", busy, frame_err); end
      idle_cycles(1);
      n_tests++; if (frame_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_expire got err=%b busy=%b want 1/0", frame_err, busy); end
      idle_cycles(TMO + 5);
      n_tests++; if (fe_count - fe0 !== 1) begin n_fail++; $display("FAIL tmo_pulses got %0d want 1", fe_count - fe0); end
      n_tests++; if (pt !== P1 || frame_cnt !== 16'd2) begin n_fail++; $display("FAIL tmo_hold got pt=%h cnt=%0d", pt, frame_cnt); end
      fv0 = fv_count;
      send_frame(P0, K0, C0, 0, -1, 0);
      idle_cycles(2);
      n_tests++; if (fv_count - fv0 !== 1 || frame_cnt !== 16'd3 || pt !== P0 || ct !== C0) begin n_fail++; $display("FAIL tmo_next got fv=%0d cnt=%0d pt=%h", fv_count - fv0, frame_cnt, pt); end
   endtask

   task automatic test_expiry_byte();
      int fe0, fv0;
      fe0 = fe_count;
      fv0 = fv_count;
      send_frame(P2, K0, C0, 0, 30, TMO - 1);
      idle_cycles(2);
      n_tests++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL exp_err got %0d want 0", fe_count - fe0); end
      n_tests++; if (fv_count - fv0 !== 1 || frame_cnt !== 16'd4) begin n_fail++; $display("FAIL exp_done got fv=%0d cnt=%0d want 1/4", fv_count - fv0, frame_cnt); end
      n_tests++; if (pt !== P2 || key !== K0 || ct !== C0) begin n_fail++; $display("FAIL exp_words got pt=%h key=%h ct=%h", pt, key, ct); end
   endtask

   task automatic test_reset_mid();
      rd_addr = '0;
      for (int i = 0; i < 48 + 100; i++) send_byte(8'h5A);
      rst = 1'b1;
      #2;
      n_tests++; if (pt !== 128'h0 || ct !== 128'h0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_words got pt=%h cnt=%0d want 0", pt, frame_cnt); end
      n_tests++; if (busy !== 1'b0 || rd_data !== 8'd0 || marker_seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got busy=%b rd=%0d mk=%b want 0", busy, rd_data, marker_seen); end
      idle_cycles(1);
      rst = 1'b0;
      send_frame(P0, K0, C0, 0, -1, 0);
      n_tests++; if (frame_cnt !== 16'd1 || pt !== P0) begin n_fail++; $display("FAIL rstmid_next got cnt=%0d pt=%h want 1", frame_cnt, pt); end
   endtask

   task automatic test_no_marker();
      int addrs [3];
      send_frame(P2, K0, C0, 1, -1, 0);
      n_tests++; if (marker_seen !== 1'b0 || marker_idx !== '0) begin n_fail++; $display("FAIL nomk_marker got %b/%0d want 0/0", marker_seen, marker_idx); end
      n_tests++; if (frame_cnt !== 16'd2 || pt !== P2) begin n_fail++; $display("FAIL nomk_cnt got %0d want 2", frame_cnt); end
      addrs = '{199, 200, 1023};
      foreach (addrs[j]) begin
         rd_addr = 10'(addrs[j]);
         idle_cycles(1);
         n_tests++; if (rd_data !== samp(1, addrs[j])) begin n_fail++; $display("FAIL nomk_rd[%0d] got %0d want %0d", addrs[j], rd_data, samp(1, addrs[j])); end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_back_to_back();
      test_timeout();
      test_expiry_byte();
      test_reset_mid();
      test_no_marker();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
